// File: rtl/spi_master_ctrl.sv
// SPI master controller, mode 0.
// One command per frame: 16-bit header {addr, dly}, dly dummy slots, then a 32-bit data word.
// The word captured on miso during the data slots is returned with a one-cycle rsp_valid pulse.
// All outputs come straight from registers or from decodes of the state register.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV  = 4,   // clk cycles per sclk half-period, >= 1
    parameter int unsigned ADD_LEN  = 14,
    parameter int unsigned DLY_LEN  = 2,
    parameter int unsigned HDR_LEN  = 16,  // must equal ADD_LEN + DLY_LEN
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [ADD_LEN-1:0]  i_cmd_addr,
    input  logic [DLY_LEN-1:0]  i_cmd_dly,
    input  logic [DATA_LEN-1:0] i_cmd_wdata,
    output logic                o_rsp_valid,
    output logic [DATA_LEN-1:0] o_rsp_rdata,
    output logic                o_busy,
    output logic                o_sclk,
    output logic                o_cs,
    output logic                o_mosi,
    input  logic                i_miso
);

    localparam int unsigned MAX_DLY   = (1 << DLY_LEN) - 1;
    localparam int unsigned MAX_SLOTS = HDR_LEN + MAX_DLY + DATA_LEN;
    localparam int unsigned BIT_W     = $clog2(MAX_SLOTS);
    localparam int unsigned CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] HDR_SLOTS = BIT_W'(HDR_LEN);
    localparam logic [BIT_W-1:0] DATA_M1   = BIT_W'(DATA_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold,
        StGap
    } state_t;

    // State and datapath registers
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;      // half-period counter, 0..CLK_DIV-1
    logic [BIT_W-1:0]    r_bit;      // current bit slot
    logic [DLY_LEN-1:0]  r_dly;
    logic [HDR_LEN-1:0]  r_hdr_sh;   // header bits still to be sent, next at MSB
    logic [DATA_LEN-1:0] r_wd_sh;    // data bits still to be sent, next at MSB
    logic [DATA_LEN-1:0] r_rx;       // miso capture in progress
    logic [DATA_LEN-1:0] r_rdata;
    logic                r_rsp_valid;
    logic                r_sclk;
    logic                r_cs;
    logic                r_mosi;

    // Next-state values
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [DLY_LEN-1:0]  w_dly_nxt;
    logic [HDR_LEN-1:0]  w_hdr_sh_nxt;
    logic [DATA_LEN-1:0] w_wd_sh_nxt;
    logic [DATA_LEN-1:0] w_rx_nxt;
    logic [DATA_LEN-1:0] w_rdata_nxt;
    logic                w_rsp_valid_nxt;
    logic                w_sclk_nxt;
    logic                w_cs_nxt;
    logic                w_mosi_nxt;

    // Decodes
    logic [HDR_LEN-1:0]  w_header;
    logic [BIT_W-1:0]    w_hdr_end;  // first data slot index
    logic [BIT_W-1:0]    w_last;     // last slot index of this frame
    logic [BIT_W-1:0]    w_bit_inc;
    logic                w_cnt_wrap;
    logic                w_data_slot;

    assign w_header    = {i_cmd_addr, i_cmd_dly};
    assign w_hdr_end   = HDR_SLOTS + BIT_W'(r_dly);
    assign w_last      = w_hdr_end + DATA_M1;
    assign w_bit_inc   = r_bit + 1'b1;
    assign w_cnt_wrap  = (r_cnt == CNT_LAST);
    assign w_data_slot = (r_bit >= w_hdr_end);

    assign o_cmd_ready = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_sclk      = r_sclk;
    assign o_cs        = r_cs;
    assign o_mosi      = r_mosi;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rdata;

    // Next-state logic for the frame sequencer and its datapath
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_nxt       = r_bit;
        w_dly_nxt       = r_dly;
        w_hdr_sh_nxt    = r_hdr_sh;
        w_wd_sh_nxt     = r_wd_sh;
        w_rx_nxt        = r_rx;
        w_rdata_nxt     = r_rdata;
        w_rsp_valid_nxt = 1'b0;
        w_sclk_nxt      = r_sclk;
        w_cs_nxt        = r_cs;
        w_mosi_nxt      = r_mosi;

        unique case (r_state)
            StIdle: begin
                if (i_cmd_valid) begin
                    // Slot 0 starts next cycle with the header MSB already on mosi
                    w_state_nxt  = StShift;
                    w_cs_nxt     = 1'b0;
                    w_sclk_nxt   = 1'b0;
                    w_cnt_nxt    = '0;
                    w_bit_nxt    = '0;
                    w_dly_nxt    = i_cmd_dly;
                    w_mosi_nxt   = w_header[HDR_LEN-1];
                    w_hdr_sh_nxt = {w_header[HDR_LEN-2:0], 1'b0};
                    w_wd_sh_nxt  = i_cmd_wdata;
                    w_rx_nxt     = '0;
                end
            end

            StShift: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt = '0;
                    if (!r_sclk) begin
                        // Rising sclk: sample miso, data slots only
                        w_sclk_nxt = 1'b1;
                        if (w_data_slot) begin
                            w_rx_nxt = {r_rx[DATA_LEN-2:0], i_miso};
                        end
                    end else begin
                        // End of slot: falling sclk, mosi moves to the next slot's bit
                        w_sclk_nxt = 1'b0;
                        if (r_bit == w_last) begin
                            w_state_nxt = StHold;
                        end else begin
                            w_bit_nxt = w_bit_inc;
                            if (w_bit_inc < HDR_SLOTS) begin
                                w_mosi_nxt   = r_hdr_sh[HDR_LEN-1];
                                w_hdr_sh_nxt = {r_hdr_sh[HDR_LEN-2:0], 1'b0};
                            end else if (w_bit_inc < w_hdr_end) begin
                                w_mosi_nxt = 1'b0;
                            end else begin
                                w_mosi_nxt  = r_wd_sh[DATA_LEN-1];
                                w_wd_sh_nxt = {r_wd_sh[DATA_LEN-2:0], 1'b0};
                            end
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            StHold: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt       = '0;
                    w_state_nxt     = StGap;
                    w_cs_nxt        = 1'b1;
                    w_mosi_nxt      = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rdata_nxt     = r_rx;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            StGap: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_dly       <= '0;
            r_hdr_sh    <= '0;
            r_wd_sh     <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_sclk      <= 1'b0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_dly       <= w_dly_nxt;
            r_hdr_sh    <= w_hdr_sh_nxt;
            r_wd_sh     <= w_wd_sh_nxt;
            r_rx        <= w_rx_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_sclk      <= w_sclk_nxt;
            r_cs        <= w_cs_nxt;
            r_mosi      <= w_mosi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: one instance at CLK_DIV=4, one at CLK_DIV=1.
// Bus monitors and miso slave models run on the falling clk edge.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // CLK_DIV = 4 instance
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_addr;
    logic [1:0]  cmd_dly;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso = 1'b0;

    // CLK_DIV = 1 instance
    logic        v1_valid;
    logic        v1_ready;
    logic [13:0] v1_addr;
    logic [1:0]  v1_dly;
    logic [31:0] v1_wdata;
    logic        v1_rsp_valid;
    logic [31:0] v1_rdata;
    logic        v1_busy;
    logic        v1_sclk;
    logic        v1_cs;
    logic        v1_mosi;
    logic        v1_miso = 1'b0;

    spi_master_ctrl #(.CLK_DIV(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_dly   (cmd_dly),
        .i_cmd_wdata (cmd_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_busy      (busy),
        .o_sclk      (sclk),
        .o_cs        (cs),
        .o_mosi      (mosi),
        .i_miso      (miso)
    );

    spi_master_ctrl #(.CLK_DIV(1)) dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (v1_valid),
        .o_cmd_ready (v1_ready),
        .i_cmd_addr  (v1_addr),
        .i_cmd_dly   (v1_dly),
        .i_cmd_wdata (v1_wdata),
        .o_rsp_valid (v1_rsp_valid),
        .o_rsp_rdata (v1_rdata),
        .o_busy      (v1_busy),
        .o_sclk      (v1_sclk),
        .o_cs        (v1_cs),
        .o_mosi      (v1_mosi),
        .i_miso      (v1_miso)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Cycle n is the clk period following the n-th rising edge
    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // Slave-side word and dummy count used by the miso models
    logic [31:0] tb_miso_word  = 32'h0;
    int          tb_dly        = 0;
    logic [31:0] tb_miso_word1 = 32'h0;
    int          tb_dly1       = 0;

    // Data slots return the word MSB first; header and dummy slots return noise
    function automatic logic slot_bit(input int slot, input int dly, input logic [31:0] w);
        int j;
        j = slot - 16 - dly;
        if (j >= 0 && j < 32) return w[31-j];
        return 1'($urandom);
    endfunction

    // Monitor state, CLK_DIV = 4
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;
    int          frame_rises = 0;
    int          rises_total = 0;
    int          cs_fall_cyc = 0;
    int          cs_rise_cyc = 0;
    int          rsp_cyc     = 0;
    int          rsp_cnt     = 0;
    int          sclk_cs_err = 0;
    logic [63:0] hist        = 64'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_cs === 1'b1 && cs === 1'b0) begin
                cs_fall_cyc = cyc;
                frame_rises = 0;
            end
            if (prev_cs === 1'b0 && cs === 1'b1) cs_rise_cyc = cyc;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises_total++;
                frame_rises++;
                hist = {hist[62:0], mosi};
            end
            if (sclk === 1'b1 && cs === 1'b1) sclk_cs_err++;
            if (rsp_valid === 1'b1) begin
                rsp_cyc = cyc;
                rsp_cnt++;
            end
            if (sclk === 1'b0 && cs === 1'b0) miso = slot_bit(frame_rises, tb_dly, tb_miso_word);
            prev_sclk = sclk;
            prev_cs   = cs;
        end
    end

    // Monitor state, CLK_DIV = 1
    logic        prev_sclk1 = 1'b0;
    logic        prev_cs1   = 1'b1;
    int          frame_rises1 = 0;
    int          cs_fall_cyc1 = 0;
    int          rsp_cyc1     = 0;
    int          run_err1     = 0;
    int          sclk_cs_err1 = 0;
    logic [63:0] hist1        = 64'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_cs1 === 1'b1 && v1_cs === 1'b0) begin
                cs_fall_cyc1 = cyc;
                frame_rises1 = 0;
            end
            if (v1_sclk === 1'b1 && prev_sclk1 === 1'b0) begin
                frame_rises1++;
                hist1 = {hist1[62:0], v1_mosi};
            end
            // Within a frame sclk must change every clk cycle
            if (v1_cs === 1'b0 && prev_cs1 === 1'b0 && v1_sclk === prev_sclk1) run_err1++;
            if (v1_sclk === 1'b1 && v1_cs === 1'b1) sclk_cs_err1++;
            if (v1_rsp_valid === 1'b1) rsp_cyc1 = cyc;
            if (v1_sclk === 1'b0 && v1_cs === 1'b0)
                v1_miso = slot_bit(frame_rises1, tb_dly1, tb_miso_word1);
            prev_sclk1 = v1_sclk;
            prev_cs1   = v1_cs;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a command and hold valid until accepted; t is the acceptance cycle
    task automatic start_cmd(input logic [13:0] a, input logic [1:0] d, input logic [31:0] w,
                             output int t);
        cmd_addr  = a;
        cmd_dly   = d;
        cmd_wdata = w;
        cmd_valid = 1'b1;
        tb_dly    = int'(d);
        t         = -1;
        for (int k = 0; k < 600; k++) begin
            if (cmd_ready) begin
                t = cyc;
                break;
            end
            tick();
        end
        n_checks++;
        if (t < 0) begin
            n_errors++;
            $display("FAIL accept_timeout: cmd_ready never seen, required within 600 cycles");
        end
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_wdata = ~w;
        cmd_dly   = ~d;
    endtask

    task automatic wait_rsp(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (rsp_valid) break;
        end
        n_checks++;
        if (!rsp_valid) begin
            n_errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, budget);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_dly   = '0;
        cmd_wdata = '0;
        v1_valid  = 1'b0;
        v1_addr   = '0;
        v1_dly    = '0;
        v1_wdata  = '0;
        tick();
        tick();
        tick();
        n_checks++;
        if ({cs, sclk, mosi, rsp_valid, busy, cmd_ready} !== 6'b100001) begin
            n_errors++;
            $display("FAIL reset_pins: cs,sclk,mosi,rsp_valid,busy,ready=%b required 100001",
                     {cs, sclk, mosi, rsp_valid, busy, cmd_ready});
        end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h required 00000000", rsp_rdata);
        end
        n_checks++;
        if ({v1_cs, v1_sclk, v1_busy, v1_ready} !== 4'b1001) begin
            n_errors++;
            $display("FAIL reset_div1: cs,sclk,busy,ready=%b required 1001",
                     {v1_cs, v1_sclk, v1_busy, v1_ready});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int t;
        int base;
        tb_miso_word = 32'hCAFEF00D;
        base = rises_total;
        start_cmd(14'h2A5C, 2'd0, 32'hDEADBEEF, t);
        n_checks++;
        if (cs_fall_cyc !== t + 1) begin
            n_errors++;
            $display("FAIL wr_cs_fall: cycle %0d required %0d", cs_fall_cyc, t + 1);
        end
        wait_rsp(1000);
        n_checks++;
        if (rsp_cyc !== t + 389) begin
            n_errors++;
            $display("FAIL wr_rsp_time: cycle %0d required %0d", rsp_cyc, t + 389);
        end
        n_checks++;
        if (cs_rise_cyc - cs_fall_cyc !== 388) begin
            n_errors++;
            $display("FAIL wr_cs_low: %0d cycles required 388", cs_rise_cyc - cs_fall_cyc);
        end
        n_checks++;
        if (rises_total - base !== 48) begin
            n_errors++;
            $display("FAIL wr_rises: %0d required 48", rises_total - base);
        end
        n_checks++;
        if (hist[47:0] !== 48'hA970_DEADBEEF) begin
            n_errors++;
            $display("FAIL wr_mosi: stream %h required a970deadbeef", hist[47:0]);
        end
        n_checks++;
        if (rsp_rdata !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL wr_rdata: got %h required cafef00d", rsp_rdata);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL wr_pulse: rsp_valid=%b rdata=%h required 0 cafef00d", rsp_valid,
                     rsp_rdata);
        end
        tick();
        tick();
        n_checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1 || cs !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_gap: ready=%b busy=%b cs=%b at T+392 required 0 1 1", cmd_ready,
                     busy, cs);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_ready: ready=%b busy=%b at T+393 required 1 0", cmd_ready, busy);
        end
        n_checks++;
        if (sclk_cs_err !== 0) begin
            n_errors++;
            $display("FAIL wr_sclk_cs: %0d sclk-high cycles with cs high, required 0", sclk_cs_err);
        end
    endtask

    task automatic test_read();
        int t;
        int base_rsp;
        tb_miso_word = 32'h12345678;
        base_rsp = rsp_cnt;
        start_cmd(14'h0123, 2'd1, 32'h00000000, t);
        wait_rsp(1000);
        n_checks++;
        if (rsp_rdata !== 32'h12345678) begin
            n_errors++;
            $display("FAIL rd_rdata: got %h required 12345678", rsp_rdata);
        end
        n_checks++;
        if (rsp_cyc !== t + 1 + 8 * 49 + 4) begin
            n_errors++;
            $display("FAIL rd_rsp_time: cycle %0d required %0d", rsp_cyc, t + 397);
        end
        tick();
        n_checks++;
        if (rsp_cnt - base_rsp !== 1) begin
            n_errors++;
            $display("FAIL rd_pulse: %0d rsp_valid cycles required 1", rsp_cnt - base_rsp);
        end
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_dummy();
        int t;
        tb_miso_word = 32'h89ABCDEF;
        start_cmd(14'h1234, 2'd3, 32'h0F0F1234, t);
        wait_rsp(1000);
        n_checks++;
        if (frame_rises !== 51) begin
            n_errors++;
            $display("FAIL dly_rises: %0d required 51", frame_rises);
        end
        n_checks++;
        if (hist[50:32] !== {14'h1234, 2'b11, 3'b000}) begin
            n_errors++;
            $display("FAIL dly_hdr: header+dummy %h required %h", hist[50:32],
                     {14'h1234, 2'b11, 3'b000});
        end
        n_checks++;
        if (hist[31:0] !== 32'h0F0F1234) begin
            n_errors++;
            $display("FAIL dly_data: mosi data %h required 0f0f1234", hist[31:0]);
        end
        n_checks++;
        if (rsp_cyc !== t + 1 + 8 * 51 + 4) begin
            n_errors++;
            $display("FAIL dly_rsp_time: cycle %0d required %0d", rsp_cyc, t + 413);
        end
        n_checks++;
        if (rsp_rdata !== 32'h89ABCDEF) begin
            n_errors++;
            $display("FAIL dly_rdata: got %h required 89abcdef", rsp_rdata);
        end
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int base_rsp;
        tb_miso_word = 32'h11112222;
        tb_dly    = 0;
        cmd_addr  = 14'h0AAA;
        cmd_dly   = 2'd0;
        cmd_wdata = 32'hA0A0A0A0;
        cmd_valid = 1'b1;
        t1 = -1;
        for (int k = 0; k < 600; k++) begin
            if (cmd_ready) begin
                t1 = cyc;
                break;
            end
            tick();
        end
        tick();
        // Second command queued on the pins while the first is busy
        cmd_addr  = 14'h3333;
        cmd_dly   = 2'd1;
        cmd_wdata = 32'h0B0B0B0B;
        wait_rsp(1000);
        n_checks++;
        if (rsp_cyc !== t1 + 389 || rsp_rdata !== 32'h11112222) begin
            n_errors++;
            $display("FAIL b2b_a_rsp: cycle %0d rdata %h required %0d 11112222", rsp_cyc,
                     rsp_rdata, t1 + 389);
        end
        n_checks++;
        if (hist[47:0] !== {14'h0AAA, 2'b00, 32'hA0A0A0A0}) begin
            n_errors++;
            $display("FAIL b2b_a_mosi: stream %h required %h", hist[47:0],
                     {14'h0AAA, 2'b00, 32'hA0A0A0A0});
        end
        tb_miso_word = 32'h33334444;
        tb_dly = 1;
        t2 = -1;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin
                t2 = cyc;
                break;
            end
            tick();
        end
        n_checks++;
        if (t2 !== t1 + 393) begin
            n_errors++;
            $display("FAIL b2b_accept: cycle %0d required %0d", t2, t1 + 393);
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (cs_fall_cyc - cs_rise_cyc !== 5) begin
            n_errors++;
            $display("FAIL b2b_cs_gap: %0d cycles required 5", cs_fall_cyc - cs_rise_cyc);
        end
        // Request while busy must be dropped
        cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        cmd_valid = 1'b0;
        wait_rsp(1000);
        base_rsp = rsp_cnt;
        n_checks++;
        if (rsp_cyc !== t2 + 1 + 8 * 49 + 4 || rsp_rdata !== 32'h33334444) begin
            n_errors++;
            $display("FAIL b2b_b_rsp: cycle %0d rdata %h required %0d 33334444", rsp_cyc,
                     rsp_rdata, t2 + 397);
        end
        n_checks++;
        if (frame_rises !== 49) begin
            n_errors++;
            $display("FAIL b2b_b_rises: %0d required 49", frame_rises);
        end
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if (cs !== 1'b1 || busy !== 1'b0 || rsp_cnt !== base_rsp) begin
            n_errors++;
            $display("FAIL b2b_no_queue: cs=%b busy=%b extra_rsp=%0d required 1 0 0", cs, busy,
                     rsp_cnt - base_rsp);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int base_rsp;
        tb_miso_word = 32'h0;
        start_cmd(14'h3FFF, 2'd0, 32'hFFFFFFFF, t);
        for (int k = 0; k < 400; k++) begin
            if (cyc >= t + 166) break;
            tick();
        end
        // Slot 20, high half: sclk=1 and mosi=1 just before reset
        n_checks++;
        if (sclk !== 1'b1 || mosi !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre: sclk=%b mosi=%b at slot 20 required 1 1", sclk, mosi);
        end
        base_rsp = rsp_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({cs, sclk, mosi, rsp_valid, cmd_ready, busy} !== 6'b100010) begin
            n_errors++;
            $display("FAIL rst_mid: cs,sclk,mosi,rsp_valid,ready,busy=%b required 100010",
                     {cs, sclk, mosi, rsp_valid, cmd_ready, busy});
        end
        for (int k = 0; k < 300; k++) tick();
        n_checks++;
        if (rsp_cnt !== base_rsp || cs !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_abort: extra_rsp=%0d cs=%b required 0 1", rsp_cnt - base_rsp, cs);
        end
        tb_miso_word = 32'h0BADCAFE;
        start_cmd(14'h0042, 2'd0, 32'h76543210, t);
        wait_rsp(1000);
        n_checks++;
        if (rsp_cyc !== t + 389 || rsp_rdata !== 32'h0BADCAFE || frame_rises !== 48) begin
            n_errors++;
            $display("FAIL rst_after: cycle %0d rdata %h rises %0d required %0d 0badcafe 48",
                     rsp_cyc, rsp_rdata, frame_rises, t + 389);
        end
        n_checks++;
        if (hist[47:0] !== {14'h0042, 2'b00, 32'h76543210}) begin
            n_errors++;
            $display("FAIL rst_after_mosi: stream %h required %h", hist[47:0],
                     {14'h0042, 2'b00, 32'h76543210});
        end
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_clkdiv1();
        int t;
        bit seen;
        tb_miso_word1 = 32'hA5A5F00F;
        tb_dly1  = 2;
        v1_addr  = 14'h1555;
        v1_dly   = 2'd2;
        v1_wdata = 32'h3C3C3C3C;
        v1_valid = 1'b1;
        t = -1;
        for (int k = 0; k < 20; k++) begin
            if (v1_ready) begin
                t = cyc;
                break;
            end
            tick();
        end
        tick();
        v1_valid = 1'b0;
        v1_wdata = 32'h0;
        n_checks++;
        if (cs_fall_cyc1 !== t + 1) begin
            n_errors++;
            $display("FAIL d1_cs_fall: cycle %0d required %0d", cs_fall_cyc1, t + 1);
        end
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (v1_rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || rsp_cyc1 !== t + 1 + 2 * 50 + 1) begin
            n_errors++;
            $display("FAIL d1_rsp_time: seen=%b cycle %0d required 1 %0d", seen, rsp_cyc1,
                     t + 102);
        end
        n_checks++;
        if (frame_rises1 !== 50) begin
            n_errors++;
            $display("FAIL d1_rises: %0d required 50", frame_rises1);
        end
        n_checks++;
        if (run_err1 !== 0 || sclk_cs_err1 !== 0) begin
            n_errors++;
            $display("FAIL d1_toggle: run_err=%0d sclk_cs_err=%0d required 0 0", run_err1,
                     sclk_cs_err1);
        end
        n_checks++;
        if (v1_rdata !== 32'hA5A5F00F) begin
            n_errors++;
            $display("FAIL d1_rdata: got %h required a5a5f00f", v1_rdata);
        end
        n_checks++;
        if (hist1[49:0] !== {14'h1555, 2'b10, 2'b00, 32'h3C3C3C3C}) begin
            n_errors++;
            $display("FAIL d1_mosi: stream %h required %h", hist1[49:0],
                     {14'h1555, 2'b10, 2'b00, 32'h3C3C3C3C});
        end
        tick();
        tick();
        n_checks++;
        if (v1_ready !== 1'b1 || v1_rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL d1_ready: ready=%b rsp_valid=%b at T+104 required 1 0", v1_ready,
                     v1_rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_dummy();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master that drives the testbench/DUT SPI interface pins (sclk, cs, mosi) and samples miso. It accepts one command per frame from a valid/ready command port, serialises a 16-bit header, optional dummy cycles and a 32-bit data word, and returns the 32-bit word captured on miso. It sits directly upstream of the SPI interface and is the pin-level source of every frame the slave sees.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; must be ≥1, 0 illegal
ADD_LEN, 14, address field width
DLY_LEN, 2, dummy-cycle count field width
HDR_LEN, 16, header width; must equal ADD_LEN+DLY_LEN
DATA_LEN, 32, data word width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
cmd_addr  in  ADD_LEN  header address field
cmd_dly  in  DLY_LEN  dummy sclk cycles between header and data (0-3)
cmd_wdata  in  DATA_LEN  word shifted out on mosi in data phase
rsp_valid  out  1  one-cycle pulse at frame end
rsp_rdata  out  DATA_LEN  word captured from miso; held until next rsp_valid
busy  out  1  high from acceptance cycle+1 until return to IDLE
sclk  out  1  SPI clock, mode 0 (idle low)
cs  out  1  chip select, active low
mosi  out  1  serial data out, MSB first
miso  in  1  serial data in

Behaviour:
- Reset (sync, rst=1 at a clk edge): cs=1, sclk=0, mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=1, state IDLE. Reset mid-frame aborts immediately: no rsp_valid; cs high the next cycle.
- Capture on acceptance: header={cmd_addr,cmd_dly}, dly and wdata are registered. Later input changes have no effect.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE. SHIFT covers N=HDR_LEN+dly+DATA_LEN bit slots: header, then dly dummy slots, then data.
- Timing, with D=CLK_DIV and acceptance at cycle T:
  - cs falls at T+1.
  - Bit slot i (0..N-1) starts at T+1+2D·i. sclk is low for D cycles, then high for D cycles.
  - mosi updates only at slot start: header MSB first, 0 during dummy slots, then wdata MSB first.
  - miso is sampled on the clk cycle where sclk goes 0->1, and only during data slots. Captured bits shift into rsp_rdata MSB first.
  - After slot N-1, sclk=0 and HOLD lasts D cycles.
  - At T+1+2D·N+D: cs=1, mosi=0, and rsp_valid pulses for one cycle; rsp_rdata updates in the same cycle.
  - GAP holds cs high for D cycles. cmd_ready rises at T+1+2D·N+2D.
- Frame length: exactly 48+dly sclk rising edges per frame, and sclk never toggles while cs=1.
- cmd_valid while busy is ignored and is not queued. cmd_valid held high in IDLE is accepted on the first cmd_ready cycle.
- Back-to-back commands: minimum cs-high time between frames is D+1 clk cycles (GAP plus the IDLE acceptance cycle).
- Counters: the half-period counter counts 0..D-1 and wraps; the bit counter is sized for 51 slots.
- CLK_DIV=1: sclk toggles every clk cycle, with the same slot/sample rules.

Test Plan:
- Write, D=4: addr=0x2A5C, dly=0, wdata=0xDEADBEEF → mosi serial stream is 0xA970 then 0xDEADBEEF, MSB first; 48 sclk rises; cs low for 388 cycles; rsp_valid at T+389.
- Read: miso model drives 0x12345678 on the data slots and random data on header slots → rsp_rdata=0x12345678 with a one-cycle rsp_valid; header-slot miso is ignored.
- Dummy cycles: dly=3 → 51 sclk rises; mosi=0 on slots 16-18; data bits start at slot 19; rsp_valid at T+1+8·51+4.
- Back-to-back: cmd_valid held high for two commands → second cs fall exactly D+1 cycles after first cs rise; cmd_valid asserted during busy gets no acceptance.
- Reset mid-frame: rst asserted at bit slot 20 → next cycle cs=1, sclk=0, mosi=0, no rsp_valid, cmd_ready=1; a new command then completes normally.
- CLK_DIV=1, dly=2: 50 sclk rises, each high/low for 1 clk; rsp_rdata matches the miso pattern 0xA5A5F00F.
